mem_port_arbiter: RTL and testbench

//  Shares one external memory port between instruction fetch (I side) and

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between instruction fetch (I) and data (D) requesters.
// Define ARB_TIMEOUT_EN to add a busy-state watchdog that aborts the access and pulses o_bus_err.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
`ifdef ARB_TIMEOUT_EN
    parameter int unsigned TIMEOUT      = 255,
`endif
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_i_req,
    input  logic [AW-1:0]     i_i_addr,
    output logic              o_i_ack,
    output logic [DW-1:0]     o_i_rdata,
    output logic              o_i_stall,
    input  logic              i_d_req,
    input  logic              i_d_write,
    input  logic [AW-1:0]     i_d_addr,
    input  logic [DW-1:0]     i_d_wdata,
    input  logic [DW/8-1:0]   i_d_be,
    output logic              o_d_ack,
    output logic [DW-1:0]     o_d_rdata,
    output logic              o_d_stall,
    output logic              o_m_req,
    output logic              o_m_write,
    output logic [AW-1:0]     o_m_addr,
    output logic [DW-1:0]     o_m_wdata,
    output logic [DW/8-1:0]   o_m_be,
    input  logic              i_m_ack,
    input  logic [DW-1:0]     i_m_rdata,
    output logic              o_bus_err
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [SW-1:0]   r_starve, w_starve_next;
    logic            r_m_req, w_m_req_next;
    logic            r_m_write, w_m_write_next;
    logic [AW-1:0]   r_m_addr, w_m_addr_next;
    logic [DW-1:0]   r_m_wdata, w_m_wdata_next;
    logic [BW-1:0]   r_m_be, w_m_be_next;

    logic            w_busy;
    logic            w_starved;
    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_done;
    logic            w_to_arm;
    logic            w_to_hit;
    logic            w_i_ack;
    logic            w_d_ack;

    // D side wins unless I has waited through STARVE_LIMIT consecutive D grants
    assign w_busy    = (r_state != ST_IDLE);
    assign w_starved = i_i_req && (r_starve == SW'(STARVE_LIMIT));
    assign w_grant_d = (r_state == ST_IDLE) && i_d_req && !w_starved;
    assign w_grant_i = (r_state == ST_IDLE) && i_i_req && !w_grant_d;
    assign w_done    = w_busy && (i_m_ack || w_to_hit);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0]   r_tcnt;
    logic            r_bus_err;

    // Arm one cycle early so M_Req is already low and Bus_Err registered in the abort cycle
    assign w_to_arm = w_busy && !i_m_ack && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_to_hit = w_busy && (r_tcnt == TW'(TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_to_arm;
            if (w_grant_d || w_grant_i) begin
                r_tcnt <= '0;
            end else if (w_busy && (r_tcnt != TW'(TIMEOUT))) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    assign o_bus_err = r_bus_err;
`else
    assign w_to_arm  = 1'b0;
    assign w_to_hit  = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_starve  <= '0;
            r_m_req   <= 1'b0;
            r_m_write <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_be    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_starve  <= w_starve_next;
            r_m_req   <= w_m_req_next;
            r_m_write <= w_m_write_next;
            r_m_addr  <= w_m_addr_next;
            r_m_wdata <= w_m_wdata_next;
            r_m_be    <= w_m_be_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_starve_next  = r_starve;
        w_m_req_next   = r_m_req;
        w_m_write_next = r_m_write;
        w_m_addr_next  = r_m_addr;
        w_m_wdata_next = r_m_wdata;
        w_m_be_next    = r_m_be;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_next   = ST_D_BUSY;
                    w_m_req_next   = 1'b1;
                    w_m_write_next = i_d_write;
                    w_m_addr_next  = i_d_addr;
                    w_m_wdata_next = i_d_wdata;
                    w_m_be_next    = i_d_be;
                end else if (w_grant_i) begin
                    w_state_next   = ST_I_BUSY;
                    w_m_req_next   = 1'b1;
                    w_m_write_next = 1'b0;
                    w_m_addr_next  = i_i_addr;
                    w_m_wdata_next = '0;
                    w_m_be_next    = '1;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (w_done) begin
                    w_state_next = ST_IDLE;
                    w_m_req_next = 1'b0;
                end else if (w_to_arm) begin
                    w_m_req_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_m_req_next = 1'b0;
            end
        endcase

        if (!i_i_req || w_grant_i) begin
            w_starve_next = '0;
        end else if (w_grant_d && (r_starve != SW'(STARVE_LIMIT))) begin
            w_starve_next = r_starve + SW'(1);
        end
    end

    // Ack/RData follow the memory completion combinationally; an aborted access returns zero
    assign w_i_ack   = (r_state == ST_I_BUSY) && (i_m_ack || w_to_hit);
    assign w_d_ack   = (r_state == ST_D_BUSY) && (i_m_ack || w_to_hit);
    assign o_i_ack   = w_i_ack;
    assign o_d_ack   = w_d_ack;
    assign o_i_rdata = (w_i_ack && !w_to_hit) ? i_m_rdata : '0;
    assign o_d_rdata = (w_d_ack && !w_to_hit) ? i_m_rdata : '0;
    assign o_i_stall = i_i_req && !w_i_ack;
    assign o_d_stall = i_d_req && !w_d_ack;

    assign o_m_req   = r_m_req;
    assign o_m_write = r_m_write;
    assign o_m_addr  = r_m_addr;
    assign o_m_wdata = r_m_wdata;
    assign o_m_be    = r_m_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of the arbitration rules. Adds a watchdog scenario under ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    localparam int unsigned AW           = 32;
    localparam int unsigned DW           = 32;
    localparam int unsigned BW           = DW / 8;
    localparam int unsigned STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_i_req = 1'b0;
    logic [AW-1:0] i_i_addr = '0;
    logic          o_i_ack;
    logic [DW-1:0] o_i_rdata;
    logic          o_i_stall;
    logic          i_d_req = 1'b0;
    logic          i_d_write = 1'b0;
    logic [AW-1:0] i_d_addr = '0;
    logic [DW-1:0] i_d_wdata = '0;
    logic [BW-1:0] i_d_be = '0;
    logic          o_d_ack;
    logic [DW-1:0] o_d_rdata;
    logic          o_d_stall;
    logic          o_m_req;
    logic          o_m_write;
    logic [AW-1:0] o_m_addr;
    logic [DW-1:0] o_m_wdata;
    logic [BW-1:0] o_m_be;
    logic          i_m_ack = 1'b0;
    logic [DW-1:0] i_m_rdata = '0;
    logic          o_bus_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: one outstanding transaction at a time
    bit            model_en = 1'b1;
    bit            busy_m = 1'b0;
    bit            pend_m = 1'b0;
    bit            own_d_m = 1'b0;
    int            starve_m = 0;
    int            busy_len = 0;
    logic [AW-1:0] exp_addr = '0;
    logic          exp_wr = 1'b0;
    logic [BW-1:0] exp_be = '0;
    logic [DW-1:0] exp_wd = '0;
    bit            last_ack_i = 1'b0;
    bit            last_ack_d = 1'b0;

    // Agent controls
    bit            auto_drop = 1'b1;
    bit            mem_auto = 1'b0;
    bit            stray_en = 1'b0;
    bit            req_auto = 1'b0;
    int            mem_slow = 0;

    // Grant sequence observed on the memory port (1 = write/D side in the hold test)
    logic          prev_mreq = 1'b0;
    logic [31:0]   gbits = '0;
    int            gcnt = 0;
    logic [9:0]    gseq10;
    logic [9:0]    exp_seq;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
`ifdef ARB_TIMEOUT_EN
        .TIMEOUT(16),
`endif
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_i_req   (i_i_req),
        .i_i_addr  (i_i_addr),
        .o_i_ack   (o_i_ack),
        .o_i_rdata (o_i_rdata),
        .o_i_stall (o_i_stall),
        .i_d_req   (i_d_req),
        .i_d_write (i_d_write),
        .i_d_addr  (i_d_addr),
        .i_d_wdata (i_d_wdata),
        .i_d_be    (i_d_be),
        .o_d_ack   (o_d_ack),
        .o_d_rdata (o_d_rdata),
        .o_d_stall (o_d_stall),
        .o_m_req   (o_m_req),
        .o_m_write (o_m_write),
        .o_m_addr  (o_m_addr),
        .o_m_wdata (o_m_wdata),
        .o_m_be    (o_m_be),
        .i_m_ack   (i_m_ack),
        .i_m_rdata (i_m_rdata),
        .o_bus_err (o_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one cycle of DUT outputs against the model, then advance the model
    task automatic model_cycle();
        bit ir, dr, ai, ad, gi, gd;
        ir = i_i_req;
        dr = i_d_req;
        if (pend_m) begin
            busy_m   = 1'b1;
            pend_m   = 1'b0;
            busy_len = 0;
            chk("grant_addr", o_m_addr, exp_addr);
            chk("grant_write", 32'(o_m_write), 32'(exp_wr));
            chk("grant_be", 32'(o_m_be), 32'(exp_be));
            if (own_d_m) chk("grant_wdata", o_m_wdata, exp_wd);
        end
        ai = busy_m && i_m_ack && !own_d_m;
        ad = busy_m && i_m_ack && own_d_m;
        chk("m_req", 32'(o_m_req), 32'(busy_m));
        chk("i_ack", 32'(o_i_ack), 32'(ai));
        chk("d_ack", 32'(o_d_ack), 32'(ad));
        chk("i_rdata", o_i_rdata, ai ? i_m_rdata : 32'h0);
        chk("d_rdata", o_d_rdata, ad ? i_m_rdata : 32'h0);
        chk("i_stall", 32'(o_i_stall), 32'(ir && !ai));
        chk("d_stall", 32'(o_d_stall), 32'(dr && !ad));
        chk("bus_err", 32'(o_bus_err), 32'h0);
        last_ack_i = ai;
        last_ack_d = ad;
        gi = 1'b0;
        gd = 1'b0;
        if (busy_m) begin
            busy_len++;
            if (i_m_ack) busy_m = 1'b0;
        end else if (dr || ir) begin
            gd       = dr && !(ir && starve_m == int'(STARVE_LIMIT));
            gi       = !gd;
            own_d_m  = gd;
            pend_m   = 1'b1;
            exp_addr = gd ? i_d_addr : i_i_addr;
            exp_wr   = gd && i_d_write;
            exp_be   = gd ? i_d_be : 4'hF;
            exp_wd   = i_d_wdata;
        end
        if (!ir || gi) starve_m = 0;
        else if (gd && starve_m < int'(STARVE_LIMIT)) starve_m++;
    endtask

    task automatic model_reset();
        busy_m    = 1'b0;
        pend_m    = 1'b0;
        starve_m  = 0;
        prev_mreq = 1'b0;
    endtask

    // One clock: check at negedge, then drive the next cycle's inputs just after posedge
    task automatic tick();
        @(negedge clk);
        if (model_en) model_cycle();
        if (o_m_req && !prev_mreq) begin
            gbits = {gbits[30:0], o_m_write};
            gcnt++;
        end
        prev_mreq = o_m_req;
        @(posedge clk);
        #1;
        if (auto_drop && last_ack_i) i_i_req = 1'b0;
        if (auto_drop && last_ack_d) i_d_req = 1'b0;
        last_ack_i = 1'b0;
        last_ack_d = 1'b0;
        i_m_ack = 1'b0;
        if (mem_auto) begin
            if (busy_m || pend_m) begin
                if (busy_len >= 6 || $urandom_range(0, mem_slow) == 0) begin
                    i_m_ack   = 1'b1;
                    i_m_rdata = $urandom;
                end
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                i_m_ack   = 1'b1;
                i_m_rdata = $urandom;
            end
        end
        if (req_auto) begin
            if (!i_i_req && $urandom_range(0, 2) == 0) begin
                i_i_req  = 1'b1;
                i_i_addr = $urandom;
            end
            if (!i_d_req && $urandom_range(0, 2) == 0) begin
                i_d_req   = 1'b1;
                i_d_write = 1'($urandom_range(0, 1));
                i_d_addr  = $urandom;
                i_d_be    = 4'($urandom);
                i_d_wdata = $urandom;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;

        // Reset values, with a memory ack forced to show it cannot leak through
        i_m_ack   = 1'b1;
        i_m_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req", 32'(o_m_req), 32'h0);
        chk("rst_m_write", 32'(o_m_write), 32'h0);
        chk("rst_m_addr", o_m_addr, 32'h0);
        chk("rst_m_wdata", o_m_wdata, 32'h0);
        chk("rst_m_be", 32'(o_m_be), 32'h0);
        chk("rst_i_ack", 32'(o_i_ack), 32'h0);
        chk("rst_d_ack", 32'(o_d_ack), 32'h0);
        chk("rst_i_rdata", o_i_rdata, 32'h0);
        chk("rst_d_rdata", o_d_rdata, 32'h0);
        chk("rst_bus_err", 32'(o_bus_err), 32'h0);
        i_m_ack = 1'b0;
        rst_n   = 1'b1;
        tick();

        // Single fetch: M_Req in cycle 1, ack in cycle 3
        i_i_req  = 1'b1;
        i_i_addr = 32'h40;
        tick();
        chk("t1_mreq_c1", 32'(o_m_req), 32'h1);
        chk("t1_maddr", o_m_addr, 32'h40);
        chk("t1_mbe", 32'(o_m_be), 32'hF);
        chk("t1_mwrite", 32'(o_m_write), 32'h0);
        tick();
        tick();
        i_m_ack   = 1'b1;
        i_m_rdata = 32'h8C01_0004;
        #1;
        chk("t1_iack_c3", 32'(o_i_ack), 32'h1);
        chk("t1_irdata_c3", o_i_rdata, 32'h8C01_0004);
        chk("t1_dack_c3", 32'(o_d_ack), 32'h0);
        tick();
        chk("t1_mreq_c4", 32'(o_m_req), 32'h0);
        tick();

        // Simultaneous requests: D first, then I after one idle cycle
        i_i_req   = 1'b1;
        i_i_addr  = 32'h80;
        i_d_req   = 1'b1;
        i_d_write = 1'b1;
        i_d_addr  = 32'h100;
        i_d_be    = 4'b0011;
        i_d_wdata = 32'hA5A5_1234;
        tick();
        chk("t2_d_write", 32'(o_m_write), 32'h1);
        chk("t2_d_addr", o_m_addr, 32'h100);
        chk("t2_d_be", 32'(o_m_be), 32'h3);
        chk("t2_d_wdata", o_m_wdata, 32'hA5A5_1234);
        tick();
        i_m_ack   = 1'b1;
        i_m_rdata = 32'h0;
        #1;
        chk("t2_d_ack", 32'(o_d_ack), 32'h1);
        chk("t2_i_ack_nonowner", 32'(o_i_ack), 32'h0);
        chk("t2_i_stall", 32'(o_i_stall), 32'h1);
        tick();
        chk("t2_idle_gap", 32'(o_m_req), 32'h0);
        tick();
        chk("t2_i_grant_req", 32'(o_m_req), 32'h1);
        chk("t2_i_grant_addr", o_m_addr, 32'h80);
        chk("t2_i_grant_write", 32'(o_m_write), 32'h0);
        rd        = $urandom;
        i_m_ack   = 1'b1;
        i_m_rdata = rd;
        #1;
        chk("t2_i_ack", 32'(o_i_ack), 32'h1);
        chk("t2_i_rdata", o_i_rdata, rd);
        tick();
        i_d_write = 1'b0;
        tick();

        // Stray memory ack while idle
        i_m_ack   = 1'b1;
        i_m_rdata = 32'h1357_9BDF;
        #1;
        chk("stray_i_ack", 32'(o_i_ack), 32'h0);
        chk("stray_d_ack", 32'(o_d_ack), 32'h0);
        tick();
        chk("stray_mreq", 32'(o_m_req), 32'h0);
        tick();

        // Requester withdraws mid-access: access completes and Ack still pulses
        i_i_req  = 1'b1;
        i_i_addr = 32'h88;
        tick();
        i_i_req = 1'b0;
        tick();
        i_m_ack   = 1'b1;
        i_m_rdata = 32'h2468_ACE0;
        #1;
        chk("drop_i_ack", 32'(o_i_ack), 32'h1);
        chk("drop_i_stall", 32'(o_i_stall), 32'h0);
        tick();
        chk("drop_mreq_after", 32'(o_m_req), 32'h0);
        tick();

        // Both sides held: starvation guard yields D,D,D,D,I,D,D,D,D,I
        gbits     = '0;
        gcnt      = 0;
        auto_drop = 1'b0;
        mem_auto  = 1'b1;
        mem_slow  = 0;
        stray_en  = 1'b0;
        i_i_req   = 1'b1;
        i_i_addr  = 32'h200;
        i_d_req   = 1'b1;
        i_d_write = 1'b1;
        i_d_addr  = 32'h300;
        i_d_be    = 4'hF;
        i_d_wdata = 32'h0000_0001;
        for (int k = 0; k < 100 && gcnt < 10; k++) tick();
        chk("seq_count", 32'(gcnt), 32'd10);
        gseq10  = gbits[9:0];
        exp_seq = 10'b1111011110;
        chk("grant_seq", 32'(gseq10), 32'(exp_seq));
        i_i_req   = 1'b0;
        i_d_req   = 1'b0;
        i_d_write = 1'b0;
        auto_drop = 1'b1;
        for (int k = 0; k < 20 && (busy_m || pend_m); k++) tick();
        chk("seq_drain", 32'(busy_m || pend_m), 32'h0);
        mem_auto = 1'b0;
        tick();

        // Asynchronous reset while D owns the port
        i_d_req   = 1'b1;
        i_d_write = 1'b1;
        i_d_addr  = 32'h500;
        i_d_be    = 4'hC;
        i_d_wdata = 32'h0000_55AA;
        tick();
        tick();
        chk("rst_pre_mreq", 32'(o_m_req), 32'h1);
        i_m_ack = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("rst_mid_mreq", 32'(o_m_req), 32'h0);
        chk("rst_mid_d_ack", 32'(o_d_ack), 32'h0);
        chk("rst_mid_maddr", o_m_addr, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_mreq", 32'(o_m_req), 32'h0);
        rst_n     = 1'b1;
        i_m_ack   = 1'b0;
        i_d_req   = 1'b0;
        i_d_write = 1'b0;
        i_i_req   = 1'b1;
        i_i_addr  = 32'h44;
        tick();
        chk("post_rst_mreq", 32'(o_m_req), 32'h1);
        chk("post_rst_maddr", o_m_addr, 32'h44);
        i_m_ack   = 1'b1;
        i_m_rdata = 32'h1234_5678;
        #1;
        chk("post_rst_i_ack", 32'(o_i_ack), 32'h1);
        chk("post_rst_i_rdata", o_i_rdata, 32'h1234_5678);
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort in cycle 17 with Bus_Err and a zero-data Ack
        model_en  = 1'b0;
        i_m_rdata = 32'hDEAD_BEEF;
        i_i_req   = 1'b1;
        i_i_addr  = 32'h60;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
        end
        chk("to_c16_bus_err", 32'(o_bus_err), 32'h0);
        chk("to_c16_mreq", 32'(o_m_req), 32'h1);
        chk("to_c16_i_ack", 32'(o_i_ack), 32'h0);
        @(posedge clk);
        #1;
        chk("to_c17_bus_err", 32'(o_bus_err), 32'h1);
        chk("to_c17_i_ack", 32'(o_i_ack), 32'h1);
        chk("to_c17_i_rdata", o_i_rdata, 32'h0);
        chk("to_c17_mreq", 32'(o_m_req), 32'h0);
        i_i_req = 1'b0;
        @(posedge clk);
        #1;
        chk("to_c18_bus_err", 32'(o_bus_err), 32'h0);
        chk("to_c18_i_ack", 32'(o_i_ack), 32'h0);
        model_reset();
        model_en = 1'b1;
        tick();
`endif

        // Randomized traffic with variable memory latency and stray acks
        req_auto = 1'b1;
        mem_auto = 1'b1;
        mem_slow = 2;
        stray_en = 1'b1;
        for (int k = 0; k < 1500; k++) tick();
        req_auto = 1'b0;
        stray_en = 1'b0;
        i_i_req  = 1'b0;
        i_d_req  = 1'b0;
        for (int k = 0; k < 20 && (busy_m || pend_m); k++) tick();
        chk("final_drain", 32'(busy_m || pend_m), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
